// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding data-memory responder with configurable wait states.
// Ports: clk/rst (sync, active-high); req_* valid/ready request channel (wen, byte addr,
//        size, right-aligned wdata); resp_* valid/ready response channel (rdata, err).
module dmem_resp #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state, state_nxt;
   logic [3:0]          cnt;
   logic                l_wen;
   logic [ADDR_W+1:0]   l_addr;
   logic [1:0]          l_size;
   logic [31:0]         l_wdata;
   logic [31:0]         mem [2**ADDR_W];

   logic                accept;
   logic                req_err;
   logic                do_access;
   logic                a_wen;
   logic [ADDR_W+1:0]   a_addr;
   logic [1:0]          a_size;
   logic [31:0]         a_wdata;
   logic [ADDR_W-1:0]   widx;
   logic [31:0]         rd_shift;
   logic [31:0]         load_data;
   logic [3:0]          be;
   logic [31:0]         wdata_rep;

   assign accept = (state == IDLE) && req_valid;

   // Reject illegal size, misalignment, and any address bit above the store.
   always_comb begin
      req_err = 1'b0;
      if (req_size == 2'b11)                             req_err = 1'b1;
      if (req_size == 2'b01 && req_addr[0])              req_err = 1'b1;
      if (req_size == 2'b10 && req_addr[1:0] != 2'b00)   req_err = 1'b1;
      if ((req_addr >> (ADDR_W + 2)) != 32'd0)           req_err = 1'b1;
   end

   // With zero wait states the access happens on the accept edge, straight
   // from the request inputs; otherwise it uses the latched copy.
   always_comb begin
      if (state == IDLE) begin
         a_wen   = req_wen;
         a_addr  = req_addr[ADDR_W+1:0];
         a_size  = req_size;
         a_wdata = req_wdata;
      end else begin
         a_wen   = l_wen;
         a_addr  = l_addr;
         a_size  = l_size;
         a_wdata = l_wdata;
      end
   end

   always_comb begin
      do_access = 1'b0;
      if (state == IDLE)
         do_access = accept && !req_err && (LATENCY == 0);
      else if (state == WAIT)
         do_access = (cnt == 4'd1);
   end

   assign widx     = a_addr[ADDR_W+1:2];
   assign rd_shift = mem[widx] >> {a_addr[1:0], 3'b000};

   always_comb begin
      load_data = rd_shift;
      be        = 4'b1111;
      wdata_rep = a_wdata;
      case (a_size)
         2'b00: begin
            load_data = {24'd0, rd_shift[7:0]};
            be        = 4'b0001 << a_addr[1:0];
            wdata_rep = {4{a_wdata[7:0]}};
         end
         2'b01: begin
            load_data = {16'd0, rd_shift[15:0]};
            be        = a_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{a_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Memory is never cleared; a reset on the access edge suppresses the write.
   always_ff @(posedge clk) begin
      if (do_access && a_wen && !rst) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_valid)
                  state_nxt = (req_err || LATENCY == 0) ? RESP : WAIT;
         WAIT: if (cnt == 4'd1) state_nxt = RESP;
         RESP: if (resp_ready)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
   end

   // Request capture, wait counter and response data.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= 4'd0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         l_wen      <= 1'b0;
         l_addr     <= '0;
         l_size     <= 2'b00;
         l_wdata    <= 32'd0;
      end else begin
         if (accept) begin
            l_wen      <= req_wen;
            l_addr     <= req_addr[ADDR_W+1:0];
            l_size     <= req_size;
            l_wdata    <= req_wdata;
            resp_err   <= req_err;
            resp_rdata <= 32'd0;
            cnt        <= (req_err || LATENCY == 0) ? 4'd0 : 4'(LATENCY);
         end
         if (state == WAIT)
            cnt <= cnt - 4'd1;
         // Later assignment wins over the clear done at accept.
         if (do_access && !a_wen)
            resp_rdata <= load_data;
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: exercises dmem_resp (LATENCY 2 and LATENCY 0 builds) against
// a byte-array reference model, fixed vectors and multi-cycle corner cases.
module tb_dmem_resp;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;
   logic        v2, v0, rr2, rr0;
   logic        rdy2, rdy0, rv2, rv0, er2, er0;
   logic [31:0] rd2, rd0;

   dmem_resp #(.ADDR_W(10), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_wen(req_wen),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .resp_valid(rv2), .resp_ready(rr2), .resp_rdata(rd2), .resp_err(er2));

   dmem_resp #(.ADDR_W(10), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_wen(req_wen),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .resp_valid(rv0), .resp_ready(rr0), .resp_rdata(rd0), .resp_err(er0));

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] ref_mem [4096];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: little-endian byte store; sizes are 1/2/4 bytes at the byte address.
   function automatic void model(input logic wen, input logic [31:0] a, input logic [1:0] sz,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int nb;
      er = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
           || (a >= 32'd4096);
      rd = 32'd0;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if (!er) begin
         for (int i = 0; i < nb; i++) begin
            if (wen) ref_mem[(a + i) % 4096] = wd[8*i +: 8];
            else     rd[8*i +: 8] = ref_mem[(a + i) % 4096];
         end
      end
   endfunction

   // One full transaction; lat = negedges after the accept edge until resp_valid seen.
   task automatic xact(input bit w0, input logic wen, input logic [31:0] addr,
                       input logic [1:0] size, input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      chk("req_ready_idle", w0 ? rdy0 : rdy2, 1'b1);
      req_wen = wen; req_addr = addr; req_size = size; req_wdata = wd;
      if (w0) v0 = 1'b1; else v2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v0 = 1'b0; v2 = 1'b0;
      // Inputs changing after accept must not matter.
      req_addr = $urandom; req_wdata = $urandom; req_wen = ~wen; req_size = 2'($urandom);
      lat = 1;
      while (!(w0 ? rv0 : rv2) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      repeat (hold) @(negedge clk);
      rd = w0 ? rd0 : rd2;
      er = w0 ? er0 : er2;
      if (w0) rr0 = 1'b1; else rr2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rr0 = 1'b0; rr2 = 1'b0;
   endtask

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [1:0]  sz;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_er;
      int          exp_lat;
   } vec_t;

   vec_t        tbl [11];
   logic [31:0] rd, mrd;
   logic        er, mer;
   int          lat;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 32'h100,  2'd2, 32'hDEADBEEF, 32'h0,        1'b0, 3};
      tbl[1]  = '{1'b0, 32'h100,  2'd2, 32'h0,        32'hDEADBEEF, 1'b0, 3};
      tbl[2]  = '{1'b1, 32'h40,   2'd2, 32'h11223344, 32'h0,        1'b0, 3};
      tbl[3]  = '{1'b1, 32'h42,   2'd0, 32'h000000AA, 32'h0,        1'b0, 3};
      tbl[4]  = '{1'b0, 32'h40,   2'd2, 32'h0,        32'h11AA3344, 1'b0, 3};
      tbl[5]  = '{1'b0, 32'h42,   2'd1, 32'h0,        32'h000011AA, 1'b0, 3};
      tbl[6]  = '{1'b0, 32'h43,   2'd0, 32'h0,        32'h00000011, 1'b0, 3};
      tbl[7]  = '{1'b0, 32'h41,   2'd1, 32'h0,        32'h0,        1'b1, 1};
      tbl[8]  = '{1'b0, 32'h1002, 2'd2, 32'h0,        32'h0,        1'b1, 1};
      tbl[9]  = '{1'b1, 32'h0,    2'd3, 32'hFFFFFFFF, 32'h0,        1'b1, 1};
      tbl[10] = '{1'b0, 32'h0,    2'd2, 32'h0,        32'h0,        1'b0, 3};

      rst = 1'b1; v2 = 1'b0; v0 = 1'b0; rr2 = 1'b0; rr0 = 1'b0;
      req_wen = 1'b0; req_addr = 32'd0; req_size = 2'd0; req_wdata = 32'd0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", rv2, 1'b0);
      chk("rst_resp_err", er2, 1'b0);
      chk("rst_resp_rdata", rd2, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", rdy2, 1'b1);
      chk("rst_req_ready_l0", rdy0, 1'b1);

      // Memory is not cleared by reset: give it known zero contents.
      for (int i = 0; i < 1024; i++)
         xact(1'b0, 1'b1, 32'(i * 4), 2'd2, 32'h0, 0, rd, er, lat);

      // Fixed vectors
      for (int i = 0; i < 11; i++) begin
         model(tbl[i].wen, tbl[i].addr, tbl[i].sz, tbl[i].wd, mrd, mer);
         xact(1'b0, tbl[i].wen, tbl[i].addr, tbl[i].sz, tbl[i].wd, i % 3, rd, er, lat);
         chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("vec%0d_err", i), er, tbl[i].exp_er);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      end

      // Back-pressure: response held stable for 5 cycles
      @(negedge clk);
      req_wen = 1'b0; req_addr = 32'h100; req_size = 2'd2; v2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v2 = 1'b0;
      for (int i = 0; i < 40 && !rv2; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", rv2, 1'b1);
         chk("bp_rdata", rd2, 32'hDEADBEEF);
         chk("bp_err", er2, 1'b0);
         chk("bp_req_ready", rdy2, 1'b0);
         @(negedge clk);
      end
      rr2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rr2 = 1'b0;
      chk("bp_done_valid", rv2, 1'b0);
      chk("bp_done_ready", rdy2, 1'b1);

      // Reset mid-WAIT, landing on the would-be access edge
      @(negedge clk);
      req_wen = 1'b1; req_addr = 32'h10; req_size = 2'd0; req_wdata = 32'h55; v2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v2 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("rstwait_no_resp", rv2, 1'b0);
         @(negedge clk);
      end
      chk("rstwait_ready", rdy2, 1'b1);
      xact(1'b0, 1'b0, 32'h10, 2'd0, 32'h0, 0, rd, er, lat);
      chk("rstwait_load", rd, 32'h0);

      // Reset during RESP drops the response
      @(negedge clk);
      req_wen = 1'b0; req_addr = 32'h40; req_size = 2'd2; v2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v2 = 1'b0;
      for (int i = 0; i < 40 && !rv2; i++) @(negedge clk);
      chk("rstresp_pre_valid", rv2, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rstresp_valid", rv2, 1'b0);
      chk("rstresp_rdata", rd2, 32'h0);
      chk("rstresp_ready", rdy2, 1'b1);

      // LATENCY = 0 build
      xact(1'b1, 1'b1, 32'h20, 2'd2, 32'hCAFEF00D, 0, rd, er, lat);
      chk("l0_store_lat", 32'(lat), 32'd1);
      xact(1'b1, 1'b0, 32'h20, 2'd2, 32'h0, 0, rd, er, lat);
      chk("l0_load_word", rd, 32'hCAFEF00D);
      chk("l0_load_lat", 32'(lat), 32'd1);
      xact(1'b1, 1'b0, 32'h21, 2'd0, 32'h0, 1, rd, er, lat);
      chk("l0_load_byte", rd, 32'h000000F0);
      chk("l0_load_err", er, 1'b0);

      // Randomized traffic against the reference model
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a, wd;
         logic [1:0]  sz;
         logic        wen;
         int          s;
         a = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(12, 31));
         s = $urandom_range(0, 7);
         sz = (s == 7) ? 2'd3 : (s > 2) ? 2'd2 : 2'(s);
         wen = 1'($urandom_range(0, 1));
         wd = $urandom;
         model(wen, a, sz, wd, mrd, mer);
         xact(1'b0, wen, a, sz, wd, $urandom_range(0, 2), rd, er, lat);
         chk("rnd_rdata", rd, mrd);
         chk("rnd_err", er, mer);
         chk("rnd_lat", 32'(lat), mer ? 32'd1 : 32'd3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
